// File: rtl/q_max_scheduler_pkg.sv
// Shared Q-learning definitions (package q_pkg): scheduler FSM states, signed compare, default widths.
// Imported by the max scheduler and by the Q-update datapath.
package q_pkg;

  localparam int Q_DATA_WIDTH = 32;
  localparam int Q_CHANNELS   = 8;

  // Wide enough for any supported Q-value; callers sign-extend into it.
  localparam int Q_CMP_WIDTH  = 64;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } q_state_e;

  function automatic logic q_gt(input logic signed [Q_CMP_WIDTH-1:0] a,
                                input logic signed [Q_CMP_WIDTH-1:0] b);
    return a > b;
  endfunction

endpackage

// File: rtl/q_max_scheduler_if.sv
// Signal bundle between the max scheduler, the Q-table RAM, the max tree and the Q-update pipeline.
// res_idx exists only when Q_MAX_ARGMAX_EN is defined.
interface q_max_scheduler_if #(
  parameter int CHANNELS    = q_pkg::Q_CHANNELS,
  parameter int DATA_WIDTH  = q_pkg::Q_DATA_WIDTH,
  parameter int NUM_CHUNKS  = 4,
  parameter int STATE_WIDTH = 8,
  parameter int ADDR_WIDTH  = STATE_WIDTH + $clog2(NUM_CHUNKS) + 1,
  parameter int IDX_WIDTH   = $clog2(CHANNELS * NUM_CHUNKS)
);

  logic                           start_valid;
  logic                           start_ready;
  logic [STATE_WIDTH-1:0]         state_idx;
  logic                           ram_rd_en;
  logic [ADDR_WIDTH-1:0]          ram_rd_addr;
  logic [DATA_WIDTH*CHANNELS-1:0] ram_rd_data;
  logic                           max_en;
  logic [DATA_WIDTH*CHANNELS-1:0] max_in_data;
  logic [DATA_WIDTH-1:0]          max_out;
  logic                           res_valid;
  logic                           res_ready;
  logic [DATA_WIDTH-1:0]          res_max;
  logic                           busy;
`ifdef Q_MAX_ARGMAX_EN
  logic [IDX_WIDTH-1:0]           res_idx;

  modport master (
    input  start_valid, state_idx, ram_rd_data, max_out, res_ready,
    output start_ready, ram_rd_en, ram_rd_addr, max_en, max_in_data,
           res_valid, res_max, busy, res_idx
  );

  modport slave (
    output start_valid, state_idx, ram_rd_data, max_out, res_ready,
    input  start_ready, ram_rd_en, ram_rd_addr, max_en, max_in_data,
           res_valid, res_max, busy, res_idx
  );
`else
  modport master (
    input  start_valid, state_idx, ram_rd_data, max_out, res_ready,
    output start_ready, ram_rd_en, ram_rd_addr, max_en, max_in_data,
           res_valid, res_max, busy
  );

  modport slave (
    output start_valid, state_idx, ram_rd_data, max_out, res_ready,
    input  start_ready, ram_rd_en, ram_rd_addr, max_en, max_in_data,
           res_valid, res_max, busy
  );
`endif

endinterface

// File: rtl/q_max_scheduler_lane_match.sv
// q_lane_match: finds the lowest lane of a RAM word whose value equals the max-tree output.
// Used for argmax tracking when Q_MAX_ARGMAX_EN is defined.
module q_lane_match #(
  parameter int CHANNELS   = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LANE_WIDTH = $clog2(CHANNELS)
) (
  input  logic [DATA_WIDTH*CHANNELS-1:0] data,
  input  logic [DATA_WIDTH-1:0]          key,
  output logic [LANE_WIDTH-1:0]          lane
);

  // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    lane = '0;
    // Scanning downwards lets the lowest matching lane win.
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (data[i*DATA_WIDTH +: DATA_WIDTH] == key) begin
        lane = LANE_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/q_max_scheduler.sv
// q_max_scheduler: streams a state's Q-row through the external max tree chunk by chunk and returns max Q.
// Optional argmax output res_idx is built when Q_MAX_ARGMAX_EN is defined.
module q_max_scheduler
  import q_pkg::*;
#(
  parameter int CHANNELS    = Q_CHANNELS,
  parameter int DATA_WIDTH  = Q_DATA_WIDTH,
  parameter int NUM_CHUNKS  = 4,
  parameter int STATE_WIDTH = 8,
  parameter int ADDR_WIDTH  = STATE_WIDTH + $clog2(NUM_CHUNKS) + 1
) (
  input logic             clk,
  input logic             rst,
  q_max_scheduler_if.master q
);

  localparam int CNT_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NUM_CHUNKS - 1);

  q_state_e               st;
  logic [STATE_WIDTH-1:0] state_q;
  logic [CNT_W-1:0]       chunk_q;   // chunk whose address is being issued
  logic [CNT_W-1:0]       beat_q;    // chunk whose data is on the bus when dv_q is high
  logic                   rd_en_q;
  logic                   dv_q;
  logic                   res_valid_q;
  logic [DATA_WIDTH-1:0]  acc_q;
  logic                   take;

  // First beat always loads; later beats replace only on strictly greater, so ties keep the earlier value.
  assign take = (beat_q == '0) ||
                q_gt(Q_CMP_WIDTH'($signed(q.max_out)), Q_CMP_WIDTH'($signed(acc_q)));

  assign q.start_ready = (st == S_IDLE);
  assign q.busy        = (st != S_IDLE);
  assign q.ram_rd_en   = rd_en_q;
  assign q.ram_rd_addr = ADDR_WIDTH'(state_q) * ADDR_WIDTH'(NUM_CHUNKS) + ADDR_WIDTH'(chunk_q);
  assign q.max_en      = dv_q;
  assign q.max_in_data = q.ram_rd_data;
  assign q.res_valid   = res_valid_q;
  assign q.res_max     = acc_q;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      st          <= S_IDLE;
      state_q     <= '0;
      chunk_q     <= '0;
      beat_q      <= '0;
      rd_en_q     <= 1'b0;
      dv_q        <= 1'b0;
      res_valid_q <= 1'b0;
      acc_q       <= '0;
    end else begin
      dv_q <= rd_en_q;
      if (dv_q) begin
        beat_q <= beat_q + CNT_W'(1);
        if (take) acc_q <= q.max_out;
      end

      case (st)
        S_IDLE: begin
          if (q.start_valid) begin
            state_q <= q.state_idx;
            chunk_q <= '0;
            beat_q  <= '0;
            rd_en_q <= 1'b1;
            st      <= S_RUN;
          end
        end
        S_RUN: begin
          if (chunk_q == LAST_CHUNK) begin
            rd_en_q <= 1'b0;
            st      <= S_DRAIN;
          end else begin
            chunk_q <= chunk_q + CNT_W'(1);
          end
        end
        S_DRAIN: begin
          // The last data beat is folded into acc_q on this same edge.
          res_valid_q <= 1'b1;
          st          <= S_DONE;
        end
        S_DONE: begin
          if (q.res_ready) begin
            res_valid_q <= 1'b0;
            st          <= S_IDLE;
          end
        end
        default: st <= S_IDLE;
      endcase
    end
  end

`ifdef Q_MAX_ARGMAX_EN
  localparam int IDX_W  = $clog2(CHANNELS * NUM_CHUNKS);
  localparam int LANE_W = $clog2(CHANNELS);

  logic [LANE_W-1:0] lane;
  logic [IDX_W-1:0]  cand;
  logic [IDX_W-1:0]  idx_q;

  q_lane_match #(
    .CHANNELS   (CHANNELS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_lane_match (
    .data (q.ram_rd_data),
    .key  (q.max_out),
    .lane (lane)
  );

  assign cand      = IDX_W'(beat_q) * IDX_W'(CHANNELS) + IDX_W'(lane);
  assign q.res_idx = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
    end else if (dv_q && take) begin
      idx_q <= cand;
    end
  end
`endif

endmodule

// File: doc/q_max_scheduler.md
Name: q_max_scheduler

Overview:
- Sequencer that computes max Q over all actions of one state when ACTIONS exceeds the channel count of the combinational max tree (top_max).
- Streams the state's Q-row from Q-table RAM in CHANNELS-wide chunks and drives each chunk through the external max tree.
- Keeps a running signed max across chunks, then returns the result on a valid/ready handshake to the Q-update pipeline.

Parameters:
- CHANNELS, 8, lanes per RAM word and per max-tree pass; power of two ≥2.
- DATA_WIDTH, 32, Q-value width; signed two's complement.
- NUM_CHUNKS, 4, RAM words per state (ACTIONS = CHANNELS*NUM_CHUNKS); ≥1.
- STATE_WIDTH, 8, width of state index.
- ADDR_WIDTH, STATE_WIDTH+$clog2(NUM_CHUNKS)+1, Q-table address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_valid  in  1  request present.
- start_ready  out  1  high only in IDLE.
- state_idx  in  STATE_WIDTH  state to evaluate; sampled on start handshake.
- ram_rd_en  out  1  Q-table read strobe.
- ram_rd_addr  out  ADDR_WIDTH  state_idx*NUM_CHUNKS + chunk.
- ram_rd_data  in  DATA_WIDTH*CHANNELS  read data, valid exactly 1 cycle after ram_rd_en.
- max_en  out  1  enable to max tree; high while a chunk is presented.
- max_in_data  out  DATA_WIDTH*CHANNELS  chunk to max tree; equals ram_rd_data (combinational pass-through).
- max_out  in  DATA_WIDTH  combinational max of the current chunk from the tree.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_max  out  DATA_WIDTH  max Q of the state.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (rst=1 at edge): FSM→IDLE; res_valid=0, ram_rd_en=0, max_en=0, res_max=0, chunk counter=0, data-valid pipe bit=0. Reset overrides any in-flight request; a pending result is discarded.
- FSM: IDLE, RUN, DRAIN, DONE.
- IDLE: start_ready=1. On start_valid, latch state_idx → RUN.
- RUN: ram_rd_en=1 each cycle; addr chunk 0..NUM_CHUNKS-1 consecutively. After the last chunk is issued → DRAIN.
- DRAIN: no read; consume the final data beat → DONE.
- Data pipe: dv register = ram_rd_en delayed 1 cycle; max_en=dv.
- Accumulator on dv: first chunk loads max_out; later chunks take acc = ($signed(max_out) > $signed(acc)) ? max_out : acc. Ties keep the earlier value.
- DONE: res_valid=1 and res_max stable until res_ready; on handshake → IDLE.
- res_valid is never dropped without res_ready.
- Latency: start accepted at cycle T → res_valid at T+NUM_CHUNKS+2. Throughput: one request per NUM_CHUNKS+3 cycles minimum.
- NUM_CHUNKS=1: RUN lasts one cycle; same FSM path.
- start_valid outside IDLE is ignored (start_ready=0). state_idx changes after the handshake have no effect.
- Width rules: address computed at ADDR_WIDTH, no truncation. Comparison is full-width signed; the most negative value is handled correctly.

Optional Feature:
- Macro: Q_MAX_ARGMAX_EN.
- Defined:
  - Adds output res_idx [$clog2(CHANNELS*NUM_CHUNKS)-1:0].
  - On each dv beat, lane_idx = lowest lane whose ram_rd_data slice equals max_out.
  - Candidate index = chunk*CHANNELS + lane_idx; it updates with acc under the same strict-greater rule.
  - res_idx is valid with res_valid; reset value 0.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package q_pkg holds:
  - FSM state enum.
  - Signed compare function q_gt.
  - Constants for default DATA_WIDTH and CHANNELS, reused by the Q-update datapath.
- One natural sub-module, q_lane_match: combinational lowest-index equality finder, instantiated only under Q_MAX_ARGMAX_EN.
- The max tree stays external; this block only drives and consumes it.

Test Plan:
- Basic: CHANNELS=8, NUM_CHUNKS=4, state 3 holding row values 0..31 with 17 set to 1000 → ram_rd_addr 12,13,14,15; res_max=1000 at T+6; res_idx=17.
- Negatives: all Q=-5 except one -1 in chunk 3 → res_max=-1. All Q=0x80000000 → res_max=0x80000000.
- Ties: value 50 in lane 2 of chunk 0 and in lane 6 of chunk 2 → res_max=50, res_idx=2.
- Backpressure: res_ready=0 for 10 cycles → res_valid and res_max held; start_ready=0; a second start_valid is not accepted until 1 cycle after the handshake.
- Reset mid-RUN: assert rst during chunk 1 → next cycle IDLE, res_valid=0, ram_rd_en=0. A new request then completes correctly.
- NUM_CHUNKS=1 build: single read at addr=state_idx → res_valid at T+3.
